// File: rtl/alarm_controller.sv
// Alarm-clock controller: alarm-time setting, edge-triggered ringing, timeout, stop and optional snooze.
// Optional feature macro: ALARM_SNOOZE_EN (builds the SNOOZE state, snooze counter and snooze_btn handling).
module alarm_controller #(
  parameter int SNOOZE_MINUTES       = 5,
  parameter int RING_TIMEOUT_MINUTES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       minute_tick,
  input  logic [7:0] cur_hour_bcd,
  input  logic [7:0] cur_min_bcd,
  input  logic       alarm_en,
  input  logic       set_btn,
  input  logic       inc_hour_btn,
  input  logic       inc_min_btn,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic [7:0] alarm_hour_bcd,
  output logic [7:0] alarm_min_bcd,
  output logic       buzzer,
  output logic       setting,
  output logic       snoozing
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SET_ALARM = 2'd1;
  localparam logic [1:0] RINGING   = 2'd2;
`ifdef ALARM_SNOOZE_EN
  localparam logic [1:0] SNOOZE    = 2'd3;
  localparam logic [3:0] SNZ_LIM   = 4'(SNOOZE_MINUTES);
`endif
  localparam logic [3:0] RING_LIM  = 4'(RING_TIMEOUT_MINUTES);

  logic [1:0] state, state_nxt;
  logic       match, match_q;
  logic [3:0] ring_cnt, ring_cnt_nxt;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [7:0] bcd_inc_min(input logic [7:0] v);
    if (v >= 8'h59)           return 8'h00;
    else if (v[3:0] >= 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_inc_hour(input logic [7:0] v);
    if (v >= 8'h23)           return 8'h00;
    else if (v[3:0] >= 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign match = (cur_hour_bcd == alarm_hour_bcd) && (cur_min_bcd == alarm_min_bcd);

`ifdef ALARM_SNOOZE_EN
  logic [3:0] snz_cnt, snz_cnt_nxt;
`else
  logic [4:0] unused_snooze;
  assign unused_snooze = {snooze_btn, 4'(SNOOZE_MINUTES)};
`endif

  // Next-state logic: disable and button transitions take priority over minute ticks.
  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_nxt  = snz_cnt;
`endif
    case (state)
      IDLE: begin
        if (set_btn)                            state_nxt = SET_ALARM;
        else if (match && !match_q && alarm_en) state_nxt = RINGING;
      end
      SET_ALARM: begin
        if (set_btn) state_nxt = IDLE;
      end
      RINGING: begin
        if (!alarm_en || stop_btn) state_nxt = IDLE;
`ifdef ALARM_SNOOZE_EN
        else if (snooze_btn)       state_nxt = SNOOZE;
`endif
        else if (minute_tick) begin
          ring_cnt_nxt = sat_inc(ring_cnt);
          if (ring_cnt_nxt >= RING_LIM) state_nxt = IDLE;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (!alarm_en || stop_btn) state_nxt = IDLE;
        else if (minute_tick) begin
          snz_cnt_nxt = sat_inc(snz_cnt);
          if (snz_cnt_nxt >= SNZ_LIM) state_nxt = RINGING;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    // Counters only hold a value while in their own state, so every entry starts from zero.
    if (state_nxt != RINGING) ring_cnt_nxt = 4'd0;
`ifdef ALARM_SNOOZE_EN
    if (state_nxt != SNOOZE)  snz_cnt_nxt  = 4'd0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      match_q        <= 1'b1;
      ring_cnt       <= 4'd0;
      alarm_hour_bcd <= 8'h07;
      alarm_min_bcd  <= 8'h00;
      buzzer         <= 1'b0;
      setting        <= 1'b0;
    end else begin
      state    <= state_nxt;
      match_q  <= match;
      ring_cnt <= ring_cnt_nxt;
      buzzer   <= (state_nxt == RINGING);
      setting  <= (state_nxt == SET_ALARM);
      if (state == SET_ALARM) begin
        if (inc_hour_btn) alarm_hour_bcd <= bcd_inc_hour(alarm_hour_bcd);
        if (inc_min_btn)  alarm_min_bcd  <= bcd_inc_min(alarm_min_bcd);
      end
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snz_cnt  <= 4'd0;
      snoozing <= 1'b0;
    end else begin
      snz_cnt  <= snz_cnt_nxt;
      snoozing <= (state_nxt == SNOOZE);
    end
  end
`else
  assign snoozing = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios plus randomized traffic against a behavioural model.
module tb_alarm_controller;
  localparam int SNZ = 5;
  localparam int RT  = 10;

  logic clk = 1'b0, rst_n = 1'b0;
  logic minute_tick = 1'b0, alarm_en = 1'b1, set_btn = 1'b0, inc_hour_btn = 1'b0;
  logic inc_min_btn = 1'b0, snooze_btn = 1'b0, stop_btn = 1'b0;
  int cur_h = 7, cur_m = 0;
  logic [7:0] cur_hour_bcd, cur_min_bcd, alarm_hour_bcd, alarm_min_bcd;
  logic buzzer, setting, snoozing;
  logic [18:0] obs;
  int errors = 0, checks = 0;

  typedef enum int {M_IDLE, M_SET, M_RING, M_SNOOZE} mode_t;
  mode_t m_mode;
  int m_ah, m_am, m_left;
  bit m_prev;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) + (v % 10));
  endfunction

  assign cur_hour_bcd = to_bcd(cur_h);
  assign cur_min_bcd  = to_bcd(cur_m);
  assign obs = {alarm_hour_bcd, alarm_min_bcd, buzzer, setting, snoozing};

  alarm_controller #(.SNOOZE_MINUTES(SNZ), .RING_TIMEOUT_MINUTES(RT)) dut (
    .clk(clk), .rst_n(rst_n), .minute_tick(minute_tick),
    .cur_hour_bcd(cur_hour_bcd), .cur_min_bcd(cur_min_bcd), .alarm_en(alarm_en),
    .set_btn(set_btn), .inc_hour_btn(inc_hour_btn), .inc_min_btn(inc_min_btn),
    .snooze_btn(snooze_btn), .stop_btn(stop_btn),
    .alarm_hour_bcd(alarm_hour_bcd), .alarm_min_bcd(alarm_min_bcd),
    .buzzer(buzzer), .setting(setting), .snoozing(snoozing)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] expect_out();
    return {to_bcd(m_ah), to_bcd(m_am), m_mode == M_RING, m_mode == M_SET, m_mode == M_SNOOZE};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ah = 7; m_am = 0; m_prev = 1'b1; m_left = 0;
  endtask

  // Behavioural model: alarm time as integers, ring/snooze as minutes remaining.
  task automatic model_advance();
    bit match;
    mode_t nxt;
    int nh, nm;
    match = (cur_h == m_ah) && (cur_m == m_am);
    nxt = m_mode; nh = m_ah; nm = m_am;
    case (m_mode)
      M_IDLE: begin
        if (set_btn) nxt = M_SET;
        else if (match && !m_prev && alarm_en) begin nxt = M_RING; m_left = RT; end
      end
      M_SET: begin
        if (inc_hour_btn) nh = (m_ah + 1) % 24;
        if (inc_min_btn)  nm = (m_am + 1) % 60;
        if (set_btn) nxt = M_IDLE;
      end
      M_RING: begin
        if (!alarm_en || stop_btn) nxt = M_IDLE;
`ifdef ALARM_SNOOZE_EN
        else if (snooze_btn) begin nxt = M_SNOOZE; m_left = SNZ; end
`endif
        else if (minute_tick) begin
          m_left--;
          if (m_left == 0) nxt = M_IDLE;
        end
      end
      M_SNOOZE: begin
        if (!alarm_en || stop_btn) nxt = M_IDLE;
        else if (minute_tick) begin
          m_left--;
          if (m_left == 0) begin nxt = M_RING; m_left = RT; end
        end
      end
      default: nxt = M_IDLE;
    endcase
    m_prev = match; m_mode = nxt; m_ah = nh; m_am = nm;
  endtask

  task automatic step();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    set_btn = 0; inc_hour_btn = 0; inc_min_btn = 0; snooze_btn = 0; stop_btn = 0; minute_tick = 0;
  endtask

  task automatic start_ring();
    cur_m = (cur_m + 1) % 60; step();
    cur_h = m_ah; cur_m = m_am; step();
  endtask

  task automatic test_reset();
    rst_n = 0; cur_h = 7; cur_m = 0; alarm_en = 1;
    model_reset();
    @(negedge clk); @(negedge clk);
    checks++;
    if (obs !== {8'h07, 8'h00, 3'b000}) begin
      errors++; $display("FAIL reset_state: got %h expected %h", obs, {8'h07, 8'h00, 3'b000});
    end
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (buzzer !== 1'b0 || obs !== expect_out()) begin
        errors++; $display("FAIL no_trigger_after_reset: got %h expected %h", obs, expect_out());
      end
    end
  endtask

  task automatic test_trigger();
    cur_m = 1; step();
    checks++;
    if (buzzer !== 1'b0) begin errors++; $display("FAIL trigger_off_time: buzzer got %b expected 0", buzzer); end
    cur_m = 0; step();
    checks++;
    if (buzzer !== 1'b1 || obs !== expect_out()) begin
      errors++; $display("FAIL trigger_on_match: got %h expected %h", obs, expect_out());
    end
    stop_btn = 1; step();
    checks++;
    if (buzzer !== 1'b0 || obs !== expect_out()) begin
      errors++; $display("FAIL stop_ringing: got %h expected %h", obs, expect_out());
    end
  endtask

  task automatic test_set_alarm();
    set_btn = 1; step();
    checks++;
    if (setting !== 1'b1) begin errors++; $display("FAIL enter_set: setting got %b expected 1", setting); end
    for (int i = 0; i < 3; i++) begin inc_hour_btn = 1; step(); end
    for (int i = 0; i < 60; i++) begin
      inc_min_btn = 1; step();
      checks++;
      if (obs !== expect_out()) begin
        errors++; $display("FAIL inc_min_%0d: got %h expected %h", i, obs, expect_out());
      end
    end
    set_btn = 1; step();
    checks++;
    if (obs !== {8'h10, 8'h00, 3'b000}) begin
      errors++; $display("FAIL set_to_1000: got %h expected %h", obs, {8'h10, 8'h00, 3'b000});
    end
  endtask

  task automatic test_bcd_wrap();
    set_btn = 1; step();
    for (int i = 0; i < 13; i++) begin inc_hour_btn = 1; step(); end
    for (int i = 0; i < 59; i++) begin inc_min_btn = 1; step(); end
    checks++;
    if ({alarm_hour_bcd, alarm_min_bcd} !== 16'h2359) begin
      errors++; $display("FAIL alarm_2359: got %h expected 2359", {alarm_hour_bcd, alarm_min_bcd});
    end
    inc_hour_btn = 1; inc_min_btn = 1; step();
    checks++;
    if ({alarm_hour_bcd, alarm_min_bcd} !== 16'h0000) begin
      errors++; $display("FAIL both_wrap: got %h expected 0000", {alarm_hour_bcd, alarm_min_bcd});
    end
    cur_h = 0; cur_m = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (buzzer !== 1'b0 || setting !== 1'b1) begin
        errors++; $display("FAIL set_suppress: buzzer/setting got %b%b expected 01", buzzer, setting);
      end
    end
    set_btn = 1; step();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== {8'h00, 8'h00, 3'b000} || obs !== expect_out()) begin
        errors++; $display("FAIL exit_set_no_trigger: got %h expected %h", obs, expect_out());
      end
    end
  endtask

  task automatic test_snooze();
    start_ring();
    checks++;
    if (buzzer !== 1'b1) begin errors++; $display("FAIL ring_before_snooze: buzzer got %b expected 1", buzzer); end
    snooze_btn = 1; step();
`ifdef ALARM_SNOOZE_EN
    checks++;
    if (snoozing !== 1'b1 || buzzer !== 1'b0) begin
      errors++; $display("FAIL snooze_entry: got %h expected %h", obs, expect_out());
    end
    for (int i = 1; i <= SNZ; i++) begin
      minute_tick = 1; step(); step();
      checks++;
      if (obs !== expect_out() || buzzer !== (i == SNZ) || snoozing !== (i < SNZ)) begin
        errors++; $display("FAIL snooze_tick_%0d: got %h expected %h", i, obs, expect_out());
      end
    end
`else
    checks++;
    if (buzzer !== 1'b1 || snoozing !== 1'b0) begin
      errors++; $display("FAIL snooze_ignored: got %h expected %h", obs, expect_out());
    end
`endif
    for (int i = 1; i <= RT; i++) begin
      minute_tick = 1; step(); step();
      checks++;
      if (obs !== expect_out() || buzzer !== (i < RT)) begin
        errors++; $display("FAIL ring_timeout_%0d: got %h expected %h", i, obs, expect_out());
      end
    end
  endtask

  task automatic test_stop_priority();
    start_ring();
    stop_btn = 1; snooze_btn = 1; minute_tick = 1; step();
    checks++;
    if (obs !== {8'h00, 8'h00, 3'b000}) begin
      errors++; $display("FAIL stop_wins: got %h expected %h", obs, {8'h00, 8'h00, 3'b000});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (buzzer !== 1'b0 || obs !== expect_out()) begin
        errors++; $display("FAIL no_retrigger: got %h expected %h", obs, expect_out());
      end
    end
  endtask

  task automatic test_enable_override();
    start_ring();
    alarm_en = 0; snooze_btn = 1; step();
    checks++;
    if (buzzer !== 1'b0 || snoozing !== 1'b0 || obs !== expect_out()) begin
      errors++; $display("FAIL enable_low: got %h expected %h", obs, expect_out());
    end
    alarm_en = 1;
  endtask

  task automatic test_async_reset();
    start_ring();
    snooze_btn = 1; step();
    #1 rst_n = 0;
    #1;
    checks++;
    if (obs !== {8'h07, 8'h00, 3'b000}) begin
      errors++; $display("FAIL async_reset: got %h expected %h", obs, {8'h07, 8'h00, 3'b000});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    step();
    checks++;
    if (obs !== expect_out()) begin
      errors++; $display("FAIL after_async_reset: got %h expected %h", obs, expect_out());
    end
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 4000; n++) begin
      set_btn      = ($urandom_range(0, 19) == 0);
      inc_hour_btn = ($urandom_range(0, 3) == 0);
      inc_min_btn  = ($urandom_range(0, 3) == 0);
      snooze_btn   = ($urandom_range(0, 9) == 0);
      stop_btn     = ($urandom_range(0, 29) == 0);
      minute_tick  = ($urandom_range(0, 2) == 0);
      alarm_en     = ($urandom_range(0, 49) != 0);
      k = int'($urandom_range(0, 9));
      if (k == 0) begin cur_h = m_ah; cur_m = m_am; end
      else if (k == 1) cur_m = (cur_m + 1) % 60;
      step();
      checks++;
      if (obs !== expect_out()) begin
        errors++; $display("FAIL random_cycle_%0d: got %h expected %h", n, obs, expect_out());
      end
    end
    alarm_en = 1;
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_set_alarm();
    test_bcd_wrap();
    test_snooze();
    test_stop_priority();
    test_enable_override();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1);
  end
endmodule
